credit_scroll_ctrl: RTL
=======================

CREDIT_SCROLL_CTRL -- requirements
Module: credit_scroll_ctrl

Interface
REQ-001 SHALL have parameter TOP_LEFT_X, default 288: fixed credit-box X position.
REQ-002 SHALL have parameter START_Y, default 480: box Y before scrolling, just below the visible area.
REQ-003 SHALL have parameter END_Y, default 380: final box Y; END_Y < START_Y.
REQ-004 SHALL have parameter DELAY_FRAMES, default 60: frames waited after game end before scrolling.
REQ-005 SHALL have parameter SCROLL_DIV, default 2: frames per 1-pixel upward step.
REQ-006 SHALL have parameter BLINK_FRAMES, default 16: frames per visibility toggle in HOLD.
REQ-007 SHALL have port clk  input  1  system clock.
REQ-008 SHALL have port resetN  input  1  asynchronous active-low reset.
REQ-009 SHALL have port startOfFrame  input  1  one-clk pulse per video frame.
REQ-010 SHALL have port gameEnded  input  1  level; high while the game is over.
REQ-011 SHALL have port restartKey  input  1  level, clk-synchronous; request to leave the credits.
REQ-012 SHALL have port creditTopLeftX  output  11  box X for the credit square object.
REQ-013 SHALL have port creditTopLeftY  output  11  box Y for the credit square object.
REQ-014 SHALL have port creditVisible  output  1  gates the credit drawing request.
REQ-015 SHALL have port scrollDone  output  1  high in HOLD.

Function
REQ-016 SHALL implement the states IDLE, DELAY, SCROLL and HOLD.
REQ-017 SHALL register every output, with no combinational path from inputs to outputs.
REQ-018 SHALL drive creditTopLeftX constantly at TOP_LEFT_X.
REQ-019 SHALL set the armed flag on a gameEnded rising edge, detected against a previous-value register that resets to 0.
REQ-020 SHALL make all transitions other than abort only on cycles where startOfFrame=1, so outputs change on the clk edge that samples startOfFrame and stay constant within a frame.
REQ-021 SHALL, in IDLE with armed=1 at startOfFrame: clear armed, clear frameCnt, go to DELAY.
REQ-022 SHALL, in DELAY: increment frameCnt per frame; when frameCnt reaches DELAY_FRAMES-1, clear frameCnt and go to SCROLL.
REQ-023 SHALL, in SCROLL: increment frameCnt per frame; when frameCnt reaches SCROLL_DIV-1, clear frameCnt and decrement Y by 1.
REQ-024 SHALL, in SCROLL, on the decrement that makes Y equal END_Y: go to HOLD with frameCnt cleared; Y never goes below END_Y.
REQ-025 SHALL, in HOLD: hold Y at END_Y and toggle creditVisible when frameCnt reaches BLINK_FRAMES-1, wrapping frameCnt to 0.
REQ-026 SHALL, in HOLD with restartKey=1 at startOfFrame: go to IDLE.
REQ-027 SHALL ignore restartKey in every state other than HOLD.
REQ-028 SHALL abort when gameEnded=0 in any state other than IDLE: go to IDLE on the next clk edge regardless of startOfFrame, and clear armed.
REQ-029 SHALL give abort priority over every other transition.
REQ-030 SHALL, on entry to IDLE: Y=START_Y, creditVisible=0, frameCnt=0.
REQ-031 SHALL drive creditVisible as 0 in IDLE and DELAY, 1 in SCROLL, 1 on HOLD entry then toggling per REQ-025.
REQ-032 SHALL drive scrollDone=1 only in HOLD.
REQ-033 SHALL size frameCnt at 8 bits; parameters are limited to 255 or less.
REQ-034 SHALL compute Y arithmetic unsigned at 11 bits.
REQ-035 SHALL, when a gameEnded rising edge and startOfFrame coincide in IDLE, leave IDLE at the next startOfFrame (one frame later), not in the same cycle.

Reset
REQ-036 SHALL, while resetN=0, asynchronously force: state=IDLE, armed=0, gameEnded previous-value register=0, frameCnt=0, creditTopLeftY=START_Y, creditVisible=0, scrollDone=0, creditTopLeftX=TOP_LEFT_X.
REQ-037 SHALL, when resetN is asserted mid-scroll, restart from IDLE with no retained position.
REQ-038 SHALL treat gameEnded already high at reset release as a rising edge (armed after the first clk).

Structure
REQ-039 SHALL take the state enum and default parameter constants from shared package end_screen_pkg.
REQ-040 SHALL use one sub-module, frame_tick_counter: 8-bit counter with clear, enable on startOfFrame, and terminal-count compare input.
REQ-041 SHALL have its outputs feed the topLeftX/topLeftY inputs of the credit square object, with creditVisible ANDed onto the credit drawing request downstream.

Verification
REQ-042 SHALL cover: reset, then gameEnded 0->1 -> DELAY at the next frame, creditVisible=0 for 60 frames, SCROLL entered with Y=480.
REQ-043 SHALL cover: a full scroll -> Y decreases by 1 every 2 frames, reaches 380 after 200 SCROLL frames, scrollDone=1, and no Y value below 380 ever appears.
REQ-044 SHALL cover: HOLD -> creditVisible toggles every 16 frames; restartKey=1 at startOfFrame -> IDLE, Y=480, visible=0.
REQ-045 SHALL cover: gameEnded dropping mid-SCROLL at Y=430, between frame pulses -> IDLE on the next clk, Y=480.
REQ-046 SHALL cover: restartKey held during DELAY and SCROLL -> no effect; resetN pulsed at Y=400 -> immediate Y=480, visible=0.
REQ-047 SHALL cover: gameEnded high at reset release -> DELAY entered at the first startOfFrame.

Source files
------------

// File: rtl/end_screen_pkg.sv
// Shared end-screen types and defaults: the credit scroller's state encoding,
// coordinate and counter widths, and default placement/timing constants.
package end_screen_pkg;

  localparam int COORD_W = 11;
  localparam int CNT_W   = 8;

  localparam int DEF_TOP_LEFT_X   = 288;
  localparam int DEF_START_Y      = 480;
  localparam int DEF_END_Y        = 380;
  localparam int DEF_DELAY_FRAMES = 60;
  localparam int DEF_SCROLL_DIV   = 2;
  localparam int DEF_BLINK_FRAMES = 16;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    SCROLL,
    HOLD
  } credit_state_t;

endpackage

// File: rtl/frame_tick_counter.sv
// Per-frame tick counter: counts enabled frames, flags the terminal value and
// wraps to zero when it advances past it.
module frame_tick_counter
  import end_screen_pkg::*;
(
  input  logic             clk,
  input  logic             resetN,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] terminal,
  output logic             at_terminal
);

  logic [CNT_W-1:0] count;

  assign at_terminal = (count == terminal);

  // Clear outranks counting so the owner can restart a phase on the same frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= at_terminal ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/credit_scroll_ctrl.sv
// End-of-game credits: waits a few frames, scrolls the credit box up into view,
// then blinks it until a restart request or the game leaving its ended state.
module credit_scroll_ctrl
  import end_screen_pkg::*;
#(
  parameter int TOP_LEFT_X   = DEF_TOP_LEFT_X,
  parameter int START_Y      = DEF_START_Y,
  parameter int END_Y        = DEF_END_Y,
  parameter int DELAY_FRAMES = DEF_DELAY_FRAMES,
  parameter int SCROLL_DIV   = DEF_SCROLL_DIV,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               gameEnded,
  input  logic               restartKey,
  output logic [COORD_W-1:0] creditTopLeftX,
  output logic [COORD_W-1:0] creditTopLeftY,
  output logic               creditVisible,
  output logic               scrollDone
);

  credit_state_t      state_q, state_d;
  logic               armed_q, armed_d;
  logic               game_ended_prev;
  logic               game_rise;
  logic [COORD_W-1:0] y_d, y_dec;
  logic               visible_d, done_d;
  logic               cnt_clear, cnt_enable, at_terminal;
  logic [CNT_W-1:0]   cnt_terminal;

  assign game_rise  = gameEnded & ~game_ended_prev;
  assign y_dec      = creditTopLeftY - 1'b1;
  assign cnt_enable = startOfFrame && (state_q != IDLE);

  always_comb begin
    cnt_terminal = '0;
    case (state_q)
      DELAY:   cnt_terminal = CNT_W'(DELAY_FRAMES - 1);
      SCROLL:  cnt_terminal = CNT_W'(SCROLL_DIV - 1);
      HOLD:    cnt_terminal = CNT_W'(BLINK_FRAMES - 1);
      default: cnt_terminal = '0;
    endcase
  end

  frame_tick_counter u_frame_cnt (
    .clk         (clk),
    .resetN      (resetN),
    .clear       (cnt_clear),
    .enable      (cnt_enable),
    .terminal    (cnt_terminal),
    .at_terminal (at_terminal)
  );

  // Abort outranks everything; other moves happen only on frame pulses.
  // A rising edge seen on the frame that consumes armed re-arms it.
  always_comb begin
    state_d   = state_q;
    armed_d   = armed_q | game_rise;
    y_d       = creditTopLeftY;
    visible_d = creditVisible;
    done_d    = scrollDone;
    cnt_clear = 1'b0;
    if ((state_q != IDLE) && !gameEnded) begin
      state_d   = IDLE;
      armed_d   = 1'b0;
      y_d       = COORD_W'(START_Y);
      visible_d = 1'b0;
      done_d    = 1'b0;
      cnt_clear = 1'b1;
    end else if (startOfFrame) begin
      case (state_q)
        IDLE: begin
          if (armed_q) begin
            state_d   = DELAY;
            armed_d   = game_rise;
            cnt_clear = 1'b1;
          end
        end
        DELAY: begin
          if (at_terminal) begin
            state_d   = SCROLL;
            visible_d = 1'b1;
            cnt_clear = 1'b1;
          end
        end
        SCROLL: begin
          if (at_terminal) begin
            if (y_dec <= COORD_W'(END_Y)) begin
              state_d   = HOLD;
              y_d       = COORD_W'(END_Y);
              visible_d = 1'b1;
              done_d    = 1'b1;
              cnt_clear = 1'b1;
            end else begin
              y_d = y_dec;
            end
          end
        end
        HOLD: begin
          if (restartKey) begin
            state_d   = IDLE;
            y_d       = COORD_W'(START_Y);
            visible_d = 1'b0;
            done_d    = 1'b0;
            cnt_clear = 1'b1;
          end else if (at_terminal) begin
            visible_d = ~creditVisible;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q         <= IDLE;
      armed_q         <= 1'b0;
      game_ended_prev <= 1'b0;
      creditTopLeftX  <= COORD_W'(TOP_LEFT_X);
      creditTopLeftY  <= COORD_W'(START_Y);
      creditVisible   <= 1'b0;
      scrollDone      <= 1'b0;
    end else begin
      state_q         <= state_d;
      armed_q         <= armed_d;
      game_ended_prev <= gameEnded;
      creditTopLeftX  <= COORD_W'(TOP_LEFT_X);
      creditTopLeftY  <= y_d;
      creditVisible   <= visible_d;
      scrollDone      <= done_d;
    end
  end

endmodule
